// File: rtl/ball_mover.sv
// Ball position register for the 8x8 pong field: serves, steps one cell per TICK_DIV cycles, freezes on game over.
// Latency: position, step_pulse and flags are registered; endgame->game_over and start->running take one cycle.
// No backpressure; optional BALL_MOVER_PAUSE_EN adds a pause input that holds the tick counter in RUN.
module ball_mover #(
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned X_INIT   = 3,
    parameter int unsigned Y_INIT   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dir_x,
    input  logic       dir_y,
    input  logic       endgame,
`ifdef BALL_MOVER_PAUSE_EN
    input  logic       pause,
`endif
    output logic [2:0] x_pos,
    output logic [2:0] y_pos,
    output logic       running,
    output logic       step_pulse,
    output logic       game_over
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [2:0] X_RST = X_INIT[2:0];
    localparam logic [2:0] Y_RST = Y_INIT[2:0];

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] tick_cnt;
    logic             hold;

`ifdef BALL_MOVER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // Saturating one-cell move: the walls are handled by the calculator, never by wrapping.
    function automatic logic [2:0] step_axis(input logic [2:0] p, input logic dec);
        if (dec)
            return (p == 3'd0) ? 3'd0 : p - 3'd1;
        else
            return (p == 3'd7) ? 3'd7 : p + 3'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            x_pos      <= X_RST;
            y_pos      <= Y_RST;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tick_cnt <= '0;
                    x_pos    <= X_RST;
                    y_pos    <= Y_RST;
                    if (start)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    // endgame beats a coincident terminal count: the miss freezes the last position
                    if (endgame) begin
                        state    <= ST_OVER;
                        tick_cnt <= '0;
                    end else if (!hold) begin
                        if (tick_cnt == CNT_LAST) begin
                            tick_cnt   <= '0;
                            x_pos      <= step_axis(x_pos, dir_x);
                            y_pos      <= step_axis(y_pos, dir_y);
                            step_pulse <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        state    <= ST_RUN;
                        tick_cnt <= '0;
                        x_pos    <= X_RST;
                        y_pos    <= Y_RST;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

    assign running   = (state == ST_RUN);
    assign game_over = (state == ST_OVER);

endmodule

// File: tb/tb_ball_mover.sv
// Randomized bench for ball_mover with a cycle-level behavioural model and literal checkpoints.
module tb_ball_mover;

    localparam int TD = 4;
    localparam int XI = 3;
    localparam int YI = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1, start = 1'b0, dir_x = 1'b0, dir_y = 1'b0, endgame = 1'b0;
    logic       pause = 1'b0;
    logic [2:0] x_pos, y_pos;
    logic       running, step_pulse, game_over;

    always #5 clk = ~clk;

    ball_mover #(.TICK_DIV(TD), .X_INIT(XI), .Y_INIT(YI)) dut (
        .clk(clk), .reset(reset), .start(start), .dir_x(dir_x), .dir_y(dir_y),
        .endgame(endgame),
`ifdef BALL_MOVER_PAUSE_EN
        .pause(pause),
`endif
        .x_pos(x_pos), .y_pos(y_pos), .running(running),
        .step_pulse(step_pulse), .game_over(game_over)
    );

    // Model: game phase, elapsed RUN cycles since the last step, and the ball cell.
    localparam int M_IDLE = 0, M_RUN = 1, M_OVER = 2;
    int m_mode, m_elapsed, m_x, m_y;
    bit m_pulse;
    int checks = 0;
    int failures = 0;

    function automatic int clamp7(input int v);
        return (v < 0) ? 0 : (v > 7) ? 7 : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit paused;
        paused = 1'b0;
`ifdef BALL_MOVER_PAUSE_EN
        paused = pause;
`endif
        m_pulse = 1'b0;
        if (reset) begin
            m_mode = M_IDLE; m_elapsed = 0; m_x = XI; m_y = YI;
        end else if (m_mode == M_IDLE) begin
            if (start) begin m_mode = M_RUN; m_elapsed = 0; end
        end else if (m_mode == M_RUN) begin
            if (endgame) begin
                m_mode = M_OVER; m_elapsed = 0;
            end else if (!paused) begin
                m_elapsed = m_elapsed + 1;
                if (m_elapsed == TD) begin
                    m_elapsed = 0;
                    m_x = clamp7(m_x + (dir_x ? -1 : 1));
                    m_y = clamp7(m_y + (dir_y ? -1 : 1));
                    m_pulse = 1'b1;
                end
            end
        end else if (start) begin
            m_mode = M_RUN; m_elapsed = 0; m_x = XI; m_y = YI;
        end
    endtask

    task automatic compare();
        chk("x_pos", x_pos, m_x);
        chk("y_pos", y_pos, m_y);
        chk("running", running, (m_mode == M_RUN) ? 1 : 0);
        chk("game_over", game_over, (m_mode == M_OVER) ? 1 : 0);
        chk("step_pulse", step_pulse, m_pulse);
    endtask

    // Inputs are set at the falling edge; the model advances on the same rising edge as the DUT.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Hand-derived expectations, applied to both DUT and model.
    task automatic lit(input string tag, input int ex, input int ey, input int er, input int ep, input int eg);
        chk({tag, ".x"}, x_pos, ex);
        chk({tag, ".y"}, y_pos, ey);
        chk({tag, ".running"}, running, er);
        chk({tag, ".pulse"}, step_pulse, ep);
        chk({tag, ".over"}, game_over, eg);
        chk({tag, ".model_x"}, m_x, ex);
        chk({tag, ".model_y"}, m_y, ey);
    endtask

    initial begin
        @(negedge clk);
        reset = 1'b1;
        cycles(2);
        lit("reset", 3, 1, 0, 0, 0);

        reset = 1'b0; start = 1'b1; dir_x = 1'b0; dir_y = 1'b0;
        cycle();
        lit("serve", 3, 1, 1, 0, 0);
        start = 1'b0;
        cycles(3);
        lit("pre_step", 3, 1, 1, 0, 0);
        cycle();
        lit("step1", 4, 2, 1, 1, 0);
        cycles(3);
        lit("between", 4, 2, 1, 0, 0);
        cycle();
        lit("step2", 5, 3, 1, 1, 0);

        cycles(4 * TD);
        lit("at_corner", 7, 7, 1, 1, 0);
        cycles(TD);
        lit("sat_high", 7, 7, 1, 1, 0);

        dir_x = 1'b1; dir_y = 1'b1;
        cycles(7 * TD);
        lit("at_origin", 0, 0, 1, 1, 0);
        cycles(TD);
        lit("sat_low", 0, 0, 1, 1, 0);

        cycles(TD - 1);
        endgame = 1'b1; start = 1'b1;
        cycle();
        lit("endgame_terminal", 0, 0, 0, 0, 1);
        endgame = 1'b0; start = 1'b0;
        cycles(3);
        lit("frozen", 0, 0, 0, 0, 1);

        start = 1'b1; dir_x = 1'b0; dir_y = 1'b0;
        cycle();
        lit("restart", 3, 1, 1, 0, 0);
        start = 1'b0;
        cycles(TD);
        lit("restart_step", 4, 2, 1, 1, 0);

`ifdef BALL_MOVER_PAUSE_EN
        cycle();
        pause = 1'b1;
        cycles(10);
        lit("paused", 4, 2, 1, 0, 0);
        pause = 1'b0;
        cycles(TD - 2);
        lit("resume_wait", 4, 2, 1, 0, 0);
        cycle();
        lit("resume_step", 5, 3, 1, 1, 0);
`endif

        cycles(2);
        reset = 1'b1; start = 1'b1;
        cycle();
        lit("mid_reset", 3, 1, 0, 0, 0);
        reset = 1'b0;
        cycle();
        lit("post_reset_start", 3, 1, 1, 0, 0);
        start = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            reset   = ($urandom_range(0, 299) == 0);
            start   = ($urandom_range(0, 7) == 0);
            endgame = ($urandom_range(0, 39) == 0);
            dir_x   = $urandom_range(0, 1) == 1;
            dir_y   = $urandom_range(0, 1) == 1;
            pause   = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
